// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, IF/ID pipeline register and retired-fetch counter.
// Optional build macro FETCH_MISALIGN_CHECK_EN aligns redirect targets and raises a sticky misalign flag.
module fetch_pc_unit #(
    parameter int                            PC_WIDTH_LENGTH   = 32,
    parameter int                            INST_WIDTH_LENGTH = 32,
    parameter logic [PC_WIDTH_LENGTH-1:0]    RESET_VECTOR      = 32'h0000_0000,
    parameter logic [INST_WIDTH_LENGTH-1:0]  NOP_INST          = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic                          redirect_i,
    input  logic [PC_WIDTH_LENGTH-1:0]    redirect_pc_i,
    input  logic [INST_WIDTH_LENGTH-1:0]  inst_i,
    output logic [PC_WIDTH_LENGTH-1:0]    pc_o,
    output logic [PC_WIDTH_LENGTH-1:0]    ifid_pc_o,
    output logic [PC_WIDTH_LENGTH-1:0]    ifid_pc_plus4_o,
    output logic [INST_WIDTH_LENGTH-1:0]  ifid_inst_o,
    output logic                          ifid_valid_o,
    output logic [31:0]                   fetch_cnt_o,
    output logic                          misalign_o
);

    localparam logic [PC_WIDTH_LENGTH-1:0] PC_STEP = PC_WIDTH_LENGTH'(4);

    logic [PC_WIDTH_LENGTH-1:0]   r_pc;
    logic [PC_WIDTH_LENGTH-1:0]   r_ifid_pc;
    logic [PC_WIDTH_LENGTH-1:0]   r_ifid_pc_plus4;
    logic [INST_WIDTH_LENGTH-1:0] r_ifid_inst;
    logic                         r_ifid_valid;
    logic [31:0]                  r_fetch_cnt;

    logic [PC_WIDTH_LENGTH-1:0]   w_pc_seq;
    logic [PC_WIDTH_LENGTH-1:0]   w_redirect_target;
    logic [PC_WIDTH_LENGTH-1:0]   w_pc_next;
    logic [PC_WIDTH_LENGTH-1:0]   w_ifid_pc_next;
    logic [PC_WIDTH_LENGTH-1:0]   w_ifid_pc_plus4_next;
    logic [INST_WIDTH_LENGTH-1:0] w_ifid_inst_next;
    logic                         w_ifid_valid_next;
    logic [31:0]                  w_fetch_cnt_next;

    // Sequential address wraps naturally modulo 2^PC_WIDTH_LENGTH.
    assign w_pc_seq = r_pc + PC_STEP;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_misalign_set;

    assign w_redirect_target = {redirect_pc_i[PC_WIDTH_LENGTH-1:2], 2'b00};
    assign w_misalign_set    = redirect_i & (redirect_pc_i[1:0] != 2'b00);

    // Sticky misalign flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_set) begin
            r_misalign <= 1'b1;
        end else begin
            r_misalign <= r_misalign;
        end
    end

    assign misalign_o = r_misalign;
`else
    assign w_redirect_target = redirect_pc_i;
    assign misalign_o        = 1'b0;
`endif

    // Next fetch address: redirect beats stall, stall beats sequential.
    always_comb begin
        w_pc_next = w_pc_seq;
        if (redirect_i) begin
            w_pc_next = w_redirect_target;
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = w_pc_seq;
        end
    end

    // Next IF/ID contents; a squash keeps the PC fields so downstream debug still sees the last address.
    always_comb begin
        w_ifid_pc_next       = r_ifid_pc;
        w_ifid_pc_plus4_next = r_ifid_pc_plus4;
        w_ifid_inst_next     = r_ifid_inst;
        w_ifid_valid_next    = r_ifid_valid;
        w_fetch_cnt_next     = r_fetch_cnt;
        if (redirect_i || flush_i) begin
            w_ifid_inst_next  = NOP_INST;
            w_ifid_valid_next = 1'b0;
        end else if (stall_i) begin
            w_ifid_valid_next = r_ifid_valid;
        end else begin
            w_ifid_pc_next       = r_pc;
            w_ifid_pc_plus4_next = w_pc_seq;
            w_ifid_inst_next     = inst_i;
            w_ifid_valid_next    = 1'b1;
            w_fetch_cnt_next     = r_fetch_cnt + 32'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc            <= RESET_VECTOR;
            r_ifid_pc       <= {PC_WIDTH_LENGTH{1'b0}};
            r_ifid_pc_plus4 <= PC_STEP;
            r_ifid_inst     <= NOP_INST;
            r_ifid_valid    <= 1'b0;
            r_fetch_cnt     <= 32'd0;
        end else begin
            r_pc            <= w_pc_next;
            r_ifid_pc       <= w_ifid_pc_next;
            r_ifid_pc_plus4 <= w_ifid_pc_plus4_next;
            r_ifid_inst     <= w_ifid_inst_next;
            r_ifid_valid    <= w_ifid_valid_next;
            r_fetch_cnt     <= w_fetch_cnt_next;
        end
    end

    assign pc_o            = r_pc;
    assign ifid_pc_o       = r_ifid_pc;
    assign ifid_pc_plus4_o = r_ifid_pc_plus4;
    assign ifid_inst_o     = r_ifid_inst;
    assign ifid_valid_o    = r_ifid_valid;
    assign fetch_cnt_o     = r_fetch_cnt;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end. Owns the program counter, presents it combinationally to the I-memory read block, and captures the returned instruction into the IF/ID pipeline register. Handles sequential increment, branch/jump redirect from EX, pipeline stall and flush from the hazard unit, and maintains a retired-fetch counter.

Parameters:
PC_WIDTH_LENGTH, 32, width of PC and all address ports
INST_WIDTH_LENGTH, 32, instruction width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
stall_i  input  1  hazard unit: hold PC and IF/ID contents
flush_i  input  1  hazard unit: squash IF/ID contents
redirect_i  input  1  EX stage: branch taken or jump
redirect_pc_i  input  PC_WIDTH_LENGTH  redirect target address
inst_i  input  INST_WIDTH_LENGTH  instruction returned by I-memory read block for pc_o
pc_o  output  PC_WIDTH_LENGTH  current fetch PC, drives I-memory read block
ifid_pc_o  output  PC_WIDTH_LENGTH  PC of instruction held in IF/ID
ifid_pc_plus4_o  output  PC_WIDTH_LENGTH  ifid_pc_o + 4
ifid_inst_o  output  INST_WIDTH_LENGTH  instruction held in IF/ID
ifid_valid_o  output  1  IF/ID holds a real instruction
fetch_cnt_o  output  32  count of instructions accepted into IF/ID
misalign_o  output  1  see Optional Feature; tied 0 when feature absent

Behaviour:
- Single clock clk; reset rst_n is synchronous, active-low, sampled on rising clk edge.
- Reset values: pc_o=RESET_VECTOR, ifid_pc_o=0, ifid_pc_plus4_o=4, ifid_inst_o=NOP_INST, ifid_valid_o=0, fetch_cnt_o=0, misalign_o=0. Reset overrides every other input, including mid-stall or mid-redirect.
- pc_o is a register output; inst_i is combinational from pc_o, sampled same edge.
- PC next-state priority: reset > redirect_i (pc<=redirect_pc_i) > stall_i (hold) > sequential (pc<=pc+4).
- PC arithmetic modulo 2^PC_WIDTH_LENGTH: 32'hFFFF_FFFC+4 wraps to 0; no flag.
- IF/ID next-state priority: reset > (redirect_i or flush_i): load NOP_INST, valid=0, pc fields keep previous values > stall_i: hold all fields > otherwise: ifid_pc<=pc_o, ifid_pc_plus4<=pc_o+4, ifid_inst<=inst_i, valid=1.
- Latency: instruction at address A appears on ifid_* exactly one cycle after pc_o=A, given no stall/flush.
- Redirect with stall_i=1 in same cycle: redirect wins; PC loads target, IF/ID squashed.
- flush_i without redirect_i: IF/ID squashed, PC still follows stall/sequential rule.
- fetch_cnt_o increments by 1 on every edge where IF/ID captures a new valid instruction (the capture branch above); wraps at 2^32; unchanged on stall, flush, redirect.
- No combinational path from any input to any output.

Optional Feature:
Macro FETCH_MISALIGN_CHECK_EN.
- Defined: on redirect_i with redirect_pc_i[1:0]!=0, PC loads redirect_pc_i with bits [1:0] forced to 0, IF/ID squashed as normal, misalign_o set to 1 next cycle and held (sticky) until reset. Other behaviour unchanged.
- Undefined: redirect_pc_i loaded unmodified; misalign_o constant 0; no extra flops.

Test Plan:
- Reset then 4 free-run cycles, inst_i=pc_o^32'hA5A5_0000 -> pc_o 0,4,8,C; ifid_valid 0,1,1,1; ifid_inst 32'hA5A5_0000 at cycle 2; fetch_cnt_o=3 after cycle 4.
- stall_i high 2 cycles at pc_o=8 -> pc_o stays 8, ifid_pc_o stays 4, fetch_cnt_o frozen; release -> pc_o=C next.
- redirect_i=1, redirect_pc_i=32'h100, stall_i=1 same cycle -> pc_o=100, ifid_inst_o=NOP_INST, ifid_valid_o=0; following cycle ifid_pc_o=100, valid=1.
- flush_i alone at pc_o=10 -> ifid_valid_o=0, ifid_inst_o=32'h13, pc_o=14.
- redirect to 32'hFFFF_FFFC then free-run -> pc_o wraps to 0, no error output.
- rst_n low mid-stall with redirect asserted -> all outputs at reset values next edge; with FETCH_MISALIGN_CHECK_EN, redirect to 32'h102 -> pc_o=100, misalign_o=1 sticky until reset.
